// File: rtl/delay_pkg.sv
// ============================================================================
// Module   : delay_pkg
// Purpose  : Shared types, default parameters and round-robin pick helper
//            for the delay scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package delay_pkg;

    localparam int c_N_DEFAULT     = 20000;
    localparam int c_CBITS_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Lowest-offset set bit at or after ptr, wrapping modulo nreq (nreq <= 8).
    function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int         nreq);
        int idx;
        rr_pick = ptr;
        for (int i = 7; i >= 0; i--) begin
            if (i < nreq) begin
                idx = (int'(ptr) + i) % nreq;
                if (req[idx[2:0]]) begin
                    rr_pick = idx[2:0];
                end
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/delay_timer.sv
// ============================================================================
// Module   : delay_timer
// Purpose  : Saturating CBITS-wide delay counter; expire flags count == N.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_timer
    import delay_pkg::*;
#(
    parameter int N     = c_N_DEFAULT,
    parameter int CBITS = c_CBITS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [CBITS-1:0] c_TERM = CBITS'(N);

    logic [CBITS-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_TERM)) begin
            r_count <= r_count + CBITS'(1);
        end
    end

    assign o_expire = (r_count == c_TERM);

endmodule

`default_nettype wire

// File: rtl/delay_sched.sv
// ============================================================================
// Module   : delay_sched
// Purpose  : Round-robin scheduler sharing one delay timer among NREQ
//            requesters, with abort detection and done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_sched
    import delay_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int N     = c_N_DEFAULT,
    parameter int CBITS = c_CBITS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic            err,
    output logic            idle
);

    state_t          r_state;
    logic [2:0]      r_owner;
    logic [2:0]      r_ptr;
    logic [2:0]      w_pick;
    logic [2:0]      w_next;
    logic [NREQ-1:0] w_own_oh;
    logic [NREQ-1:0] w_pick_oh;
    logic            w_own_req;
    logic            w_expire;
    logic            w_clear;
    logic            w_enable;

    always_comb begin
        w_own_oh  = '0;
        w_pick_oh = '0;
        w_pick    = rr_pick(8'(req), r_ptr, NREQ);
        w_next    = (r_owner == 3'(NREQ - 1)) ? 3'd0 : r_owner + 3'd1;
        for (int i = 0; i < NREQ; i++) begin
            w_own_oh[i]  = (r_owner == 3'(i));
            w_pick_oh[i] = (w_pick == 3'(i));
        end
        w_own_req = |(req & w_own_oh);
    end

    // The counter is held clear outside RUN, so each grant starts from zero.
    assign w_clear  = (r_state != RUN);
    assign w_enable = (r_state == RUN);

    delay_timer #(
        .N     (N),
        .CBITS (CBITS)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .o_expire (w_expire)
    );

    // Outputs are registered from the next-state decision so they line up
    // with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_owner <= 3'd0;
            r_ptr   <= 3'd0;
            gnt     <= '0;
            done    <= '0;
            err     <= 1'b0;
            idle    <= 1'b1;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_owner <= w_pick;
                        gnt     <= w_pick_oh;
                        idle    <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!w_own_req) begin
                        gnt     <= '0;
                        err     <= 1'b1;
                        idle    <= 1'b1;
                        r_ptr   <= w_next;
                        r_state <= IDLE;
                    end else if (w_expire) begin
                        gnt     <= '0;
                        done    <= w_own_oh;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_ptr   <= w_next;
                    idle    <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    gnt     <= '0;
                    idle    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_delay_sched.sv
// ============================================================================
// Module   : tb_delay_sched
// Purpose  : Self-checking bench for delay_sched (NREQ=4, N=5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_delay_sched;

    localparam int c_NREQ = 4;
    localparam int c_N    = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       err;
    logic       idle;

    int n_vec = 0;
    int n_err = 0;
    int tcyc  = 0;
    bit chk_en = 1'b0;

    // Timeline model: expected outputs derived from grant start times.
    int         m_cyc, m_next, m_t, m_owner, m_ptr;
    bit         m_act;
    int         mc, mn, midx;
    bit         mfound;
    logic [3:0] e_gnt, e_done;
    logic       e_err, e_idle;

    delay_sched #(
        .NREQ  (c_NREQ),
        .N     (c_N),
        .CBITS (3)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt),
        .done (done),
        .err  (err),
        .idle (idle)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) tcyc <= tcyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cyc = 0; m_next = 0; m_t = 0; m_owner = 0; m_ptr = 0; m_act = 1'b0;
            e_gnt = 4'd0; e_done = 4'd0; e_err = 1'b0; e_idle = 1'b1;
        end else begin
            mc    = m_cyc;
            e_err = 1'b0;
            if (mc >= m_next) begin
                if (req != 4'd0) begin
                    mfound = 1'b0;
                    for (int k = 0; k < c_NREQ; k++) begin
                        midx = (m_ptr + k) % c_NREQ;
                        if (!mfound && req[midx]) begin
                            m_owner = midx;
                            mfound  = 1'b1;
                        end
                    end
                    m_t    = mc;
                    m_next = mc + c_N + 3;
                    m_ptr  = (m_owner + 1) % c_NREQ;
                    m_act  = 1'b1;
                end
            end else if (m_act && mc <= m_t + c_N + 1 && !req[m_owner]) begin
                m_act  = 1'b0;
                m_next = mc + 1;
                e_err  = 1'b1;
            end
            mn     = mc + 1;
            e_gnt  = (m_act && mn >= m_t + 1 && mn <= m_t + c_N + 1) ? (4'b0001 << m_owner) : 4'd0;
            e_done = (m_act && mn == m_t + c_N + 2) ? (4'b0001 << m_owner) : 4'd0;
            e_idle = (mn >= m_next);
            m_cyc  = mn;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt", gnt, e_gnt);
            check("done", done, e_done);
            check("err", err, e_err);
            check("idle", idle, e_idle);
            check("gnt_onehot0", $onehot0(gnt), 1);
            check("done_err_excl", (|done) && err, 0);
            check("count_le_N", u_dut.u_timer.r_count <= 3'd5, 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    // Leaves the bench in cycle 0: the first IDLE cycle, sampled at its end.
    task automatic do_reset(input logic [3:0] r);
        step();
        rst = 1'b0;
        req = 4'd0;
        step();
        step();
        rst = 1'b1;
        req = r;
    endtask

    int         got, sw, gcnt, dk, seen2, lat;
    int         ord[5];
    int         dc[5];
    int         exp_ord[5] = '{0, 1, 2, 3, 0};
    int         raise[4];
    logic [3:0] pend, gprev;

    initial begin
        rst = 1'b0;
        req = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Single request
        do_reset(4'b0001);
        look();
        check("s1_idle0", idle, 1);
        check("s1_gnt0", gnt, 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 7) req = 4'd0;
            look();
            if (k <= 6) begin
                check("s1_gnt", gnt, 4'b0001);
            end else if (k == 7) begin
                check("s1_done7", done, 4'b0001);
                check("s1_gnt7", gnt, 0);
            end else begin
                check("s1_idle8", idle, 1);
                check("s1_done8", done, 0);
            end
        end

        // All requesting, then pointer wrap with 1001
        do_reset(4'b1111);
        got = 0;
        sw  = 0;
        for (int k = 0; k < 60 && got < 5; k++) begin
            step();
            if (got == 3 && sw == 0) begin
                req = 4'b1001;
                sw  = 1;
            end
            look();
            if (|done) begin
                for (int b = 0; b < 4; b++) if (done[b]) ord[got] = b;
                dc[got] = tcyc;
                got++;
            end
        end
        check("s2_done_count", got, 5);
        for (int i = 0; i < got; i++) check("s2_order", ord[i], exp_ord[i]);
        for (int i = 1; i < got; i++) check("s2_spacing", dc[i] - dc[i-1], 8);
        step();
        req = 4'd0;

        // Abort at the 3rd RUN cycle
        do_reset(4'b0100);
        look();
        step(); look();
        check("s4_gnt1", gnt, 4'b0100);
        step();
        step();
        req = 4'b0000;
        look();
        check("s4_gnt3", gnt, 4'b0100);
        step();
        req = 4'b1001;
        look();
        check("s4_err", err, 1);
        check("s4_gnt_off", gnt, 0);
        check("s4_idle", idle, 1);
        check("s4_nodone", done, 0);
        step(); look();
        check("s4_next_grant", gnt, 4'b1000);
        check("s4_err_once", err, 0);
        seen2 = 0;
        for (int k = 0; k < 10; k++) begin
            step(); look();
            if (done[2]) seen2++;
        end
        check("s4_no_done2", seen2, 0);

        // Asynchronous reset during the 4th RUN cycle
        do_reset(4'b0001);
        look();
        repeat (3) step();
        step();
        rst = 1'b0;
        look();
        check("s5_gnt", gnt, 0);
        check("s5_done", done, 0);
        check("s5_err", err, 0);
        check("s5_idle", idle, 1);
        step();
        rst = 1'b1;
        req = 4'b0010;
        gcnt = 0;
        dk   = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 7) req = 4'd0;
            look();
            if (gnt == 4'b0010) gcnt++;
            if (done == 4'b0010) dk = k;
        end
        check("s5_gnt_cycles", gcnt, 6);
        check("s5_done_cycle", dk, 7);

        // Random traffic with liveness bound 4*(N+3)
        do_reset(4'd0);
        pend  = 4'd0;
        gprev = 4'd0;
        for (int i = 0; i < 4; i++) raise[i] = 0;
        for (int k = 0; k < 1500; k++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                if (pend[i]) begin
                    if (gprev[i] && $urandom_range(0, 99) == 0) pend[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    pend[i]  = 1'b1;
                    raise[i] = tcyc;
                end
            end
            req = pend;
            look();
            for (int i = 0; i < 4; i++) begin
                lat = tcyc - raise[i];
                if (pend[i] && done[i]) begin
                    check("live_latency_ok", lat <= 4 * (c_N + 3), 1);
                    pend[i] = 1'b0;
                end else if (pend[i] && lat > 4 * (c_N + 3)) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL live_timeout: req %0d waited %0d cycles, limit %0d", i, lat, 4 * (c_N + 3));
                    pend[i] = 1'b0;
                end
            end
            gprev = gnt;
        end
        step();
        req = 4'd0;
        repeat (12) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, limit 500000");
        $fatal(1);
    end

endmodule

`default_nettype wire
